// File: rtl/note_event_tracker.sv
// rtl/note_event_tracker.sv - five-voice MIDI note/duration tracker
module note_event_tracker #(
    parameter logic [31:0] DUR_SAT = 32'd1_200_000_000
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            midi_valid_in,
    input  logic            midi_on_in,
    input  logic [6:0]      midi_velocity_in,
    input  logic [7:0]      midi_note_in,
    output logic [4:0][7:0] notes_out,
    output logic [4:0][31:0] durations_out,
    output logic [4:0]      held_out,
    output logic [4:0]      release_out,
    output logic            overflow_out
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HELD     = 2'd1,
        S_RELEASED = 2'd2
    } slot_state_t;

    localparam logic [7:0] NOTE_NONE = 8'hFF;

    slot_state_t state_q [5];
    slot_state_t state_d [5];
    logic [7:0]  note_q  [5];
    logic [7:0]  note_d  [5];
    logic [31:0] dur_q   [5];
    logic [31:0] dur_d   [5];
    logic [31:0] dur_inc [5];

    logic [4:0] release_q, release_d;
    logic       overflow_q, overflow_d;

    logic       code_ok;
    logic       ev_valid;
    logic       is_on;
    logic [4:0] free;
    logic [4:0] match_held;
    logic [4:0] alloc_oh;
    logic       do_alloc;
    logic       do_release;

    assign code_ok  = (midi_note_in[7:4] <= 4'd11) && (midi_note_in[3:0] <= 4'd8);
    assign ev_valid = midi_valid_in && code_ok;
    assign is_on    = midi_on_in && (midi_velocity_in != 7'd0);

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            free[i]       = (state_q[i] != S_HELD);
            match_held[i] = (state_q[i] == S_HELD) && (note_q[i] == midi_note_in);
            dur_inc[i]    = (dur_q[i] >= DUR_SAT) ? DUR_SAT : dur_q[i] + 32'd1;
        end
    end

    // Isolate the lowest free slot; a held code never appears twice, so match_held is one-hot.
    assign alloc_oh   = free & (~free + 5'd1);
    assign do_alloc   = ev_valid && is_on && !(|match_held) && (|free);
    assign overflow_d = ev_valid && is_on && !(|match_held) && !(|free);
    assign do_release = ev_valid && !is_on;

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            state_d[i]   = state_q[i];
            note_d[i]    = note_q[i];
            // Release freezes at the value this cycle's increment produces.
            dur_d[i]     = (state_q[i] == S_HELD) ? dur_inc[i] : dur_q[i];
            release_d[i] = 1'b0;
            if (do_alloc && alloc_oh[i]) begin
                state_d[i] = S_HELD;
                note_d[i]  = midi_note_in;
                dur_d[i]   = 32'd0;
            end
            if (do_release && match_held[i]) begin
                state_d[i]   = S_RELEASED;
                release_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= S_IDLE;
                note_q[i]  <= NOTE_NONE;
                dur_q[i]   <= 32'd0;
            end
            release_q  <= 5'd0;
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= state_d[i];
                note_q[i]  <= note_d[i];
                dur_q[i]   <= dur_d[i];
            end
            release_q  <= release_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            notes_out[i]     = note_q[i];
            durations_out[i] = dur_q[i];
            held_out[i]      = (state_q[i] == S_HELD);
        end
    end

    assign release_out  = release_q;
    assign overflow_out = overflow_q;

endmodule

// File: tb/tb_note_event_tracker.sv
// tb/tb_note_event_tracker.sv - directed bench for note_event_tracker
module tb_note_event_tracker;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic midi_valid_in = 1'b0;
    logic midi_on_in = 1'b0;
    logic [6:0] midi_velocity_in = 7'd0;
    logic [7:0] midi_note_in = 8'd0;

    logic [4:0][7:0]  notes_out, s_notes_out;
    logic [4:0][31:0] durations_out, s_durations_out;
    logic [4:0] held_out, s_held_out;
    logic [4:0] release_out, s_release_out;
    logic overflow_out, s_overflow_out;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    note_event_tracker dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .midi_valid_in(midi_valid_in), .midi_on_in(midi_on_in),
        .midi_velocity_in(midi_velocity_in), .midi_note_in(midi_note_in),
        .notes_out(notes_out), .durations_out(durations_out),
        .held_out(held_out), .release_out(release_out), .overflow_out(overflow_out)
    );

    note_event_tracker #(.DUR_SAT(32'd20)) dut_sat (
        .clk_in(clk_in), .rst_in(rst_in),
        .midi_valid_in(midi_valid_in), .midi_on_in(midi_on_in),
        .midi_velocity_in(midi_velocity_in), .midi_note_in(midi_note_in),
        .notes_out(s_notes_out), .durations_out(s_durations_out),
        .held_out(s_held_out), .release_out(s_release_out), .overflow_out(s_overflow_out)
    );

    task automatic send(input logic on, input logic [6:0] vel, input logic [7:0] note);
        @(negedge clk_in);
        midi_valid_in = 1'b1;
        midi_on_in = on;
        midi_velocity_in = vel;
        midi_note_in = note;
        @(posedge clk_in);
        #1;
        midi_valid_in = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        #12;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (notes_out[i] !== 8'hFF) begin
                n_fail++; $display("FAIL reset_note[%0d] got %h exp ff", i, notes_out[i]);
            end
            n_checks++;
            if (durations_out[i] !== 32'd0) begin
                n_fail++; $display("FAIL reset_dur[%0d] got %0d exp 0", i, durations_out[i]);
            end
        end
        n_checks++;
        if ({held_out, release_out, overflow_out} !== 11'd0) begin
            n_fail++; $display("FAIL reset_flags got %b exp 0", {held_out, release_out, overflow_out});
        end
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_hold_release();
        do_reset();
        send(1'b1, 7'd64, 8'h04);
        n_checks++;
        if (held_out !== 5'b00001 || notes_out[0] !== 8'h04 || durations_out[0] !== 32'd0) begin
            n_fail++; $display("FAIL alloc got held=%b note=%h dur=%0d exp 00001/04/0", held_out, notes_out[0], durations_out[0]);
        end
        tick(99);
        n_checks++;
        if (durations_out[0] !== 32'd99) begin
            n_fail++; $display("FAIL running_dur got %0d exp 99", durations_out[0]);
        end
        send(1'b0, 7'd0, 8'h04);
        n_checks++;
        if (release_out !== 5'b00001 || held_out !== 5'b00000 || durations_out[0] !== 32'd100) begin
            n_fail++; $display("FAIL release got rel=%b held=%b dur=%0d exp 00001/00000/100", release_out, held_out, durations_out[0]);
        end
        tick(1);
        n_checks++;
        if (release_out !== 5'b00000 || durations_out[0] !== 32'd100 || notes_out[0] !== 8'h04) begin
            n_fail++; $display("FAIL frozen got rel=%b dur=%0d note=%h exp 00000/100/04", release_out, durations_out[0], notes_out[0]);
        end
        for (int i = 1; i < 5; i++) begin
            n_checks++;
            if (notes_out[i] !== 8'hFF || durations_out[i] !== 32'd0) begin
                n_fail++; $display("FAIL idle_slot[%0d] got %h/%0d exp ff/0", i, notes_out[i], durations_out[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        codes = '{8'h04, 8'h44, 8'h74, 8'h05, 8'h45};
        do_reset();
        for (int i = 0; i < 5; i++) send(1'b1, 7'd100, codes[i]);
        send(1'b1, 7'd100, 8'h94);
        n_checks++;
        if (overflow_out !== 1'b1 || held_out !== 5'b11111) begin
            n_fail++; $display("FAIL overflow_pulse got ovf=%b held=%b exp 1/11111", overflow_out, held_out);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (notes_out[i] !== codes[i] || durations_out[i] !== 32'(5 - i)) begin
                n_fail++; $display("FAIL full_slot[%0d] got %h/%0d exp %h/%0d", i, notes_out[i], durations_out[i], codes[i], 5 - i);
            end
        end
        tick(1);
        n_checks++;
        if (overflow_out !== 1'b0) begin
            n_fail++; $display("FAIL overflow_once got %b exp 0", overflow_out);
        end
    endtask

    task automatic test_realloc();
        do_reset();
        send(1'b1, 7'd10, 8'h01);
        send(1'b1, 7'd10, 8'h21);
        send(1'b0, 7'd10, 8'h01);
        n_checks++;
        if (release_out !== 5'b00001 || held_out !== 5'b00010) begin
            n_fail++; $display("FAIL realloc_release got rel=%b held=%b exp 00001/00010", release_out, held_out);
        end
        send(1'b1, 7'd10, 8'hB3);
        n_checks++;
        if (notes_out[0] !== 8'hB3 || durations_out[0] !== 32'd0 || held_out !== 5'b00011) begin
            n_fail++; $display("FAIL realloc_slot0 got %h/%0d held=%b exp b3/0/00011", notes_out[0], durations_out[0], held_out);
        end
        n_checks++;
        if (notes_out[1] !== 8'h21 || durations_out[1] !== 32'd2) begin
            n_fail++; $display("FAIL realloc_slot1 got %h/%0d exp 21/2", notes_out[1], durations_out[1]);
        end
    endtask

    task automatic test_duplicate_vel0();
        do_reset();
        send(1'b1, 7'd64, 8'h24);
        send(1'b1, 7'd64, 8'h24);
        n_checks++;
        if (held_out !== 5'b00001 || notes_out[1] !== 8'hFF || durations_out[0] !== 32'd1) begin
            n_fail++; $display("FAIL no_retrigger got held=%b n1=%h d0=%0d exp 00001/ff/1", held_out, notes_out[1], durations_out[0]);
        end
        send(1'b1, 7'd0, 8'h24);
        n_checks++;
        if (release_out !== 5'b00001 || held_out !== 5'b00000 || durations_out[0] !== 32'd2) begin
            n_fail++; $display("FAIL vel0_release got rel=%b held=%b dur=%0d exp 00001/00000/2", release_out, held_out, durations_out[0]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        send(1'b1, 7'd64, 8'h30);
        tick(49);
        n_checks++;
        if (s_durations_out[0] !== 32'd20) begin
            n_fail++; $display("FAIL sat_hold got %0d exp 20", s_durations_out[0]);
        end
        n_checks++;
        if (durations_out[0] !== 32'd49) begin
            n_fail++; $display("FAIL nosat_hold got %0d exp 49", durations_out[0]);
        end
        send(1'b0, 7'd0, 8'h30);
        tick(3);
        n_checks++;
        if (s_durations_out[0] !== 32'd20 || s_held_out !== 5'b00000) begin
            n_fail++; $display("FAIL sat_frozen got %0d held=%b exp 20/00000", s_durations_out[0], s_held_out);
        end
    endtask

    task automatic test_invalid_and_async_reset();
        do_reset();
        send(1'b1, 7'd64, 8'hC4);
        n_checks++;
        if (held_out !== 5'b0 || notes_out[0] !== 8'hFF || overflow_out !== 1'b0 || release_out !== 5'b0) begin
            n_fail++; $display("FAIL invalid_class got held=%b n0=%h ovf=%b exp 0/ff/0", held_out, notes_out[0], overflow_out);
        end
        send(1'b1, 7'd64, 8'h09);
        n_checks++;
        if (held_out !== 5'b0 || notes_out[0] !== 8'hFF) begin
            n_fail++; $display("FAIL invalid_octave got held=%b n0=%h exp 0/ff", held_out, notes_out[0]);
        end
        send(1'b1, 7'd64, 8'h55);
        send(1'b0, 7'd0, 8'h56);
        n_checks++;
        if (release_out !== 5'b0 || held_out !== 5'b00001) begin
            n_fail++; $display("FAIL unheld_off got rel=%b held=%b exp 0/00001", release_out, held_out);
        end
        tick(5);
        #2;
        rst_in = 1'b0;
        #1;
        n_checks++;
        if (held_out !== 5'b0 || notes_out[0] !== 8'hFF || durations_out[0] !== 32'd0 || release_out !== 5'b0) begin
            n_fail++; $display("FAIL async_reset got held=%b n0=%h d0=%0d rel=%b exp 0/ff/0/0", held_out, notes_out[0], durations_out[0], release_out);
        end
        tick(1);
        n_checks++;
        if (release_out !== 5'b0) begin
            n_fail++; $display("FAIL reset_no_release got %b exp 0", release_out);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    initial begin
        test_reset();
        test_hold_release();
        test_overflow();
        test_realloc();
        test_duplicate_vel0();
        test_saturation();
        test_invalid_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
